// File: rtl/uart_rx_core.sv
// UART receiver core: 8 data bits, LSB first, one stop bit, with valid/ack handoff.
// Define UART_RX_PARITY_EN to add one even-parity bit between bit 7 and the stop bit.
module uart_rx_core #(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic       CLK,
    input  logic       reset,
    input  logic       rx_i,
    output logic [7:0] rx_byte,
    output logic       rx_valid,
    input  logic       rx_ack,
    output logic       busy_rx,
    output logic       frame_err,
    output logic       overrun_err,
    output logic       parity_err
);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef UART_RX_PARITY_EN
        PARITY,
`endif
        STOP
    } state_t;

    localparam logic [15:0] HALF_M1 = 16'(CLKS_PER_BIT / 2 - 1);
    localparam logic [15:0] FULL_M1 = 16'(CLKS_PER_BIT - 1);

    state_t      state, state_nxt;
    logic [15:0] baud_cnt;
    logic [2:0]  bit_cnt;
    logic [7:0]  shift;
    logic        rx_meta, rx_s, rx_prev;
    logic        baud_done, shift_en, par_smp, stop_smp, good, par_bad;

    // Counter holds at its ceiling rather than wrapping if a sample point is ever missed.
    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_meta <= rx_i;
            rx_s    <= rx_meta;
            rx_prev <= rx_s;
        end
    end

    always_ff @(posedge CLK or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        shift_en  = 1'b0;
        par_smp   = 1'b0;
        stop_smp  = 1'b0;
        baud_done = (state == START) ? (baud_cnt == HALF_M1) : (baud_cnt == FULL_M1);
        case (state)
            IDLE:  if (rx_prev && !rx_s) state_nxt = START;
            START: if (baud_done) state_nxt = rx_s ? IDLE : DATA;
            DATA: begin
                if (baud_done) begin
                    shift_en = 1'b1;
`ifdef UART_RX_PARITY_EN
                    if (bit_cnt == 3'd7) state_nxt = PARITY;
`else
                    if (bit_cnt == 3'd7) state_nxt = STOP;
`endif
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (baud_done) begin
                    par_smp   = 1'b1;
                    state_nxt = STOP;
                end
            end
`endif
            STOP: begin
                if (baud_done) begin
                    stop_smp  = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Baud counter restarts on every state entry and at every sample point.
    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            baud_cnt <= 16'd0;
            bit_cnt  <= 3'd0;
        end else begin
            if (state == IDLE || state_nxt != state || baud_done) baud_cnt <= 16'd0;
            else                                                  baud_cnt <= sat_inc(baud_cnt);
            if (state != DATA) bit_cnt <= 3'd0;
            else if (shift_en) bit_cnt <= bit_cnt + 3'd1;
        end
    end

    always_ff @(posedge CLK) begin
        if (shift_en) shift <= {rx_s, shift[7:1]};
    end

`ifdef UART_RX_PARITY_EN
    // Even parity: the parity bit makes the XOR over data plus parity zero.
    always_ff @(posedge CLK or posedge reset) begin
        if (reset)        par_bad <= 1'b0;
        else if (par_smp) par_bad <= rx_s ^ (^shift);
    end

    always_ff @(posedge CLK or posedge reset) begin
        if (reset) parity_err <= 1'b0;
        else       parity_err <= stop_smp && par_bad;
    end
`else
    assign par_bad    = 1'b0;
    assign parity_err = 1'b0;
`endif

    assign good    = stop_smp && rx_s && !par_bad;
    assign busy_rx = (state != IDLE);

    // A new byte takes priority over a same-cycle ack, so the fresh byte stays valid.
    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            rx_byte     <= 8'h00;
            rx_valid    <= 1'b0;
            frame_err   <= 1'b0;
            overrun_err <= 1'b0;
        end else begin
            frame_err   <= stop_smp && !rx_s;
            overrun_err <= good && rx_valid && !rx_ack;
            if (good) begin
                rx_byte  <= shift;
                rx_valid <= 1'b1;
            end else if (rx_ack) begin
                rx_valid <= 1'b0;
            end
        end
    end

endmodule
